// File: rtl/rf_port_arb.sv
// Shared-port scheduler for the 32x32 register file: arbitrates ALU/MEM writebacks and decode reads,
// keeps reads from passing older same-register writes and bounds read starvation.
module rf_port_arb #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic          t2,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_ar,
    input  logic [AW-1:0] rd_br,
    output logic          rd_gnt,
    output logic          rd_vld,
    input  logic          wa_req,
    input  logic [AW-1:0] wa_wr,
    input  logic [DW-1:0] wa_w,
    output logic          wa_gnt,
    input  logic          wm_req,
    input  logic [AW-1:0] wm_wr,
    input  logic [DW-1:0] wm_w,
    output logic          wm_gnt,
    output logic          rf_rwe,
    output logic [AW-1:0] rf_wr,
    output logic [DW-1:0] rf_w,
    output logic [AW-1:0] rf_ar,
    output logic [AW-1:0] rf_br
);

    localparam int            CW         = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] REG_ZERO   = {AW{1'b0}};

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } wsel_e;

    wsel_e          rr_q, rr_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           rwe_q, rwe_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [DW-1:0]  w_q, w_d;
    logic [AW-1:0]  ar_q, ar_d;
    logic [AW-1:0]  br_q, br_d;
    logic           rd_pend_q, rd_pend_d;
    logic           rd_vld_q, rd_vld_d;

    logic           haz_a_s, haz_m_s, both_s;
    logic           gnt_a_s, gnt_m_s, gnt_r_s, gnt_w_s;

    // A pending writer conflicts with the waiting read if it targets a real register the read uses
    always_comb begin
        haz_a_s = rd_req & wa_req & (wa_wr != REG_ZERO) & ((wa_wr == rd_ar) | (wa_wr == rd_br));
        haz_m_s = rd_req & wm_req & (wm_wr != REG_ZERO) & ((wm_wr == rd_ar) | (wm_wr == rd_br));
        both_s  = wa_req & wm_req;
    end

    // Priority arbitration: hazard writes, starvation read, round-robin writes, then plain read
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_m_s = 1'b0;
        gnt_r_s = 1'b0;
        if (!rst_n) begin
            gnt_a_s = 1'b0;
        end else if (haz_a_s | haz_m_s) begin
            if (haz_a_s & haz_m_s) begin
                gnt_a_s = (rr_q == SEL_ALU);
                gnt_m_s = (rr_q == SEL_MEM);
            end else begin
                gnt_a_s = haz_a_s;
                gnt_m_s = haz_m_s;
            end
        end else if (rd_req & (starve_q == STARVE_LIM)) begin
            gnt_r_s = 1'b1;
        end else if (both_s) begin
            gnt_a_s = (rr_q == SEL_ALU);
            gnt_m_s = (rr_q == SEL_MEM);
        end else if (wa_req) begin
            gnt_a_s = 1'b1;
        end else if (wm_req) begin
            gnt_m_s = 1'b1;
        end else if (rd_req) begin
            gnt_r_s = 1'b1;
        end else begin
            gnt_r_s = 1'b0;
        end
        gnt_w_s = gnt_a_s | gnt_m_s;
    end

    // Fairness state and the port image driven in the cycle after a grant
    always_comb begin
        rr_d      = rr_q;
        starve_d  = starve_q;
        rwe_d     = 1'b0;
        wr_d      = wr_q;
        w_d       = w_q;
        ar_d      = ar_q;
        br_d      = br_q;
        rd_pend_d = gnt_r_s;
        rd_vld_d  = rd_pend_q;

        if (gnt_w_s & both_s) begin
            rr_d = (rr_q == SEL_ALU) ? SEL_MEM : SEL_ALU;
        end else begin
            rr_d = rr_q;
        end

        if (!rd_req || gnt_r_s) begin
            starve_d = {CW{1'b0}};
        end else if (gnt_w_s && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + CNT_ONE;
        end else begin
            starve_d = starve_q;
        end

        // Writes to $0 still consume the grant but never reach the array
        if (gnt_a_s) begin
            rwe_d = (wa_wr != REG_ZERO);
            wr_d  = wa_wr;
            w_d   = wa_w;
        end else if (gnt_m_s) begin
            rwe_d = (wm_wr != REG_ZERO);
            wr_d  = wm_wr;
            w_d   = wm_w;
        end else begin
            rwe_d = 1'b0;
        end

        if (gnt_r_s) begin
            ar_d = rd_ar;
            br_d = rd_br;
        end else begin
            ar_d = ar_q;
            br_d = br_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge t2) begin
        if (!rst_n) begin
            rr_q      <= SEL_ALU;
            starve_q  <= {CW{1'b0}};
            rwe_q     <= 1'b0;
            wr_q      <= {AW{1'b0}};
            w_q       <= {DW{1'b0}};
            ar_q      <= {AW{1'b0}};
            br_q      <= {AW{1'b0}};
            rd_pend_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            starve_q  <= starve_d;
            rwe_q     <= rwe_d;
            wr_q      <= wr_d;
            w_q       <= w_d;
            ar_q      <= ar_d;
            br_q      <= br_d;
            rd_pend_q <= rd_pend_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign wa_gnt = gnt_a_s;
    assign wm_gnt = gnt_m_s;
    assign rd_gnt = gnt_r_s;
    assign rd_vld = rd_vld_q;
    assign rf_rwe = rwe_q;
    assign rf_wr  = wr_q;
    assign rf_w   = w_q;
    assign rf_ar  = ar_q;
    assign rf_br  = br_q;

endmodule

// File: tb/tb_rf_port_arb.sv
// Randomized self-checking bench for rf_port_arb: a rule-level arbitration model plus an architectural
// register image that predicts the data a read must return.
module tb_rf_port_arb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SMAX = 3;

    logic          t2 = 1'b0;
    logic          rst_n, rd_req, wa_req, wm_req;
    logic [AW-1:0] rd_ar, rd_br, wa_wr, wm_wr;
    logic [DW-1:0] wa_w, wm_w;
    logic          rd_gnt, rd_vld, wa_gnt, wm_gnt, rf_rwe;
    logic [AW-1:0] rf_wr, rf_ar, rf_br;
    logic [DW-1:0] rf_w;

    always #5 t2 = ~t2;

    rf_port_arb #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
        .t2(t2), .rst_n(rst_n),
        .rd_req(rd_req), .rd_ar(rd_ar), .rd_br(rd_br), .rd_gnt(rd_gnt), .rd_vld(rd_vld),
        .wa_req(wa_req), .wa_wr(wa_wr), .wa_w(wa_w), .wa_gnt(wa_gnt),
        .wm_req(wm_req), .wm_wr(wm_wr), .wm_w(wm_w), .wm_gnt(wm_gnt),
        .rf_rwe(rf_rwe), .rf_wr(rf_wr), .rf_w(rf_w), .rf_ar(rf_ar), .rf_br(rf_br)
    );

    // Simple register file on the arbitrated port: a/b update only on non-write cycles
    logic [DW-1:0] mem [32];
    logic [DW-1:0] rf_a, rf_b;
    always @(posedge t2) begin
        if (rf_rwe === 1'b1) begin
            mem[rf_wr] <= rf_w;
        end else begin
            rf_a <= (rf_ar == 5'd0) ? 32'd0 : mem[rf_ar];
            rf_b <= (rf_br == 5'd0) ? 32'd0 : mem[rf_br];
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit primed = 1'b0;

    // Reference model state
    bit            m_rr_mem;
    int            m_starve;
    logic [DW-1:0] arch [32];
    logic          exp_rwe;
    logic [AW-1:0] exp_wr, exp_ar, exp_br;
    logic [DW-1:0] exp_w;
    int            rd_cyc_q[$];
    logic [DW-1:0] rd_a_q[$];
    logic [DW-1:0] rd_b_q[$];
    int            last_g;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check registered outputs and grants at negedge, advance the model, step past posedge
    task automatic step();
        int  g;
        bit  ha, hm, both, exp_v;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(negedge t2);
        if (primed) begin
            chk("rf_rwe", {31'd0, rf_rwe}, {31'd0, exp_rwe});
            chk("rf_wr", {27'd0, rf_wr}, {27'd0, exp_wr});
            chk("rf_w", rf_w, exp_w);
            chk("rf_ar", {27'd0, rf_ar}, {27'd0, exp_ar});
            chk("rf_br", {27'd0, rf_br}, {27'd0, exp_br});
            exp_v = (rd_cyc_q.size() > 0) && (rd_cyc_q[0] + 2 == cyc);
            chk("rd_vld", {31'd0, rd_vld}, {31'd0, exp_v});
            if (exp_v) begin
                chk("read_a", rf_a, rd_a_q[0]);
                chk("read_b", rf_b, rd_b_q[0]);
                void'(rd_cyc_q.pop_front());
                void'(rd_a_q.pop_front());
                void'(rd_b_q.pop_front());
            end
        end

        ha   = rd_req && wa_req && wa_wr != 0 && (wa_wr == rd_ar || wa_wr == rd_br);
        hm   = rd_req && wm_req && wm_wr != 0 && (wm_wr == rd_ar || wm_wr == rd_br);
        both = wa_req && wm_req;
        if (!rst_n)                        g = 0;
        else if (ha && hm)                 g = m_rr_mem ? 2 : 1;
        else if (ha)                       g = 1;
        else if (hm)                       g = 2;
        else if (rd_req && m_starve == SMAX) g = 3;
        else if (both)                     g = m_rr_mem ? 2 : 1;
        else if (wa_req)                   g = 1;
        else if (wm_req)                   g = 2;
        else if (rd_req)                   g = 3;
        else                               g = 0;
        chk("wa_gnt", {31'd0, wa_gnt}, {31'd0, g == 1});
        chk("wm_gnt", {31'd0, wm_gnt}, {31'd0, g == 2});
        chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, g == 3});

        if (!rst_n) begin
            m_rr_mem = 1'b0;
            m_starve = 0;
            exp_rwe = 1'b0; exp_wr = '0; exp_w = '0; exp_ar = '0; exp_br = '0;
            rd_cyc_q.delete(); rd_a_q.delete(); rd_b_q.delete();
        end else begin
            exp_rwe = 1'b0;
            if (g == 1 || g == 2) begin
                wa = (g == 1) ? wa_wr : wm_wr;
                wd = (g == 1) ? wa_w : wm_w;
                exp_rwe = (wa != 0);
                exp_wr  = wa;
                exp_w   = wd;
                if (wa != 0) arch[wa] = wd;
                if (both) m_rr_mem = !m_rr_mem;
            end
            if (g == 3) begin
                exp_ar = rd_ar;
                exp_br = rd_br;
                rd_cyc_q.push_back(cyc);
                rd_a_q.push_back(arch[rd_ar]);
                rd_b_q.push_back(arch[rd_br]);
            end
            if (!rd_req || g == 3) m_starve = 0;
            else if (g == 1 || g == 2) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        end
        last_g = g;
        @(posedge t2);
        #1;
        cyc++;
        primed = 1'b1;
    endtask

    // Requesters hold until granted, then may issue a fresh request
    task automatic rand_stim();
        if (last_g == 1 || (!wa_req && $urandom_range(0, 2) == 0)) begin
            wa_req = 1'($urandom_range(0, 1));
            wa_wr  = AW'($urandom_range(0, 9));
            wa_w   = $urandom;
        end
        if (last_g == 2 || (!wm_req && $urandom_range(0, 2) == 0)) begin
            wm_req = 1'($urandom_range(0, 1));
            wm_wr  = AW'($urandom_range(0, 9));
            wm_w   = $urandom;
        end
        if (last_g == 3 || (!rd_req && $urandom_range(0, 2) == 0)) begin
            rd_req = 1'($urandom_range(0, 1));
            rd_ar  = AW'($urandom_range(0, 9));
            rd_br  = AW'($urandom_range(0, 9));
        end
        rst_n = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            mem[i]  = '0;
        end
        m_rr_mem = 1'b0; m_starve = 0; last_g = 0;
        exp_rwe = 1'b0; exp_wr = '0; exp_w = '0; exp_ar = '0; exp_br = '0;

        // Reset with everything requesting: no grants, then first grant right after release
        rst_n = 1'b0;
        rd_req = 1'b1; rd_ar = 5'd3; rd_br = 5'd4;
        wa_req = 1'b1; wa_wr = 5'd1; wa_w = 32'h1111_0001;
        wm_req = 1'b1; wm_wr = 5'd2; wm_w = 32'h2222_0002;
        step(); step();
        rst_n = 1'b1;
        step();
        wa_req = 1'b0; wm_req = 1'b0; rd_req = 1'b0;
        step(); step();

        // Single write, then a write to $0
        wa_req = 1'b1; wa_wr = 5'd5; wa_w = 32'hDEAD_BEEF;
        step();
        wa_req = 1'b0;
        wm_req = 1'b1; wm_wr = 5'd0; wm_w = 32'hFFFF_FFFF;
        step();
        wm_req = 1'b0;
        step();

        // Both writers continuously: alternating grants
        wa_req = 1'b1; wa_wr = 5'd10; wa_w = 32'hA0A0_A0A0;
        wm_req = 1'b1; wm_wr = 5'd11; wm_w = 32'hB0B0_B0B0;
        for (int i = 0; i < 4; i++) step();

        // Read against continuous writes: starvation bound forces the read through
        rd_req = 1'b1; rd_ar = 5'd3; rd_br = 5'd4;
        wa_wr = 5'd7; wm_wr = 5'd8;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_g == 3) rd_req = 1'b0;
        end
        wa_req = 1'b0; wm_req = 1'b0; rd_req = 1'b0;
        step(); step();

        // Read of a register with an older pending write: write first, read sees new data
        rd_req = 1'b1; rd_ar = 5'd9; rd_br = 5'd5;
        wm_req = 1'b1; wm_wr = 5'd9; wm_w = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_g == 2) wm_req = 1'b0;
            if (last_g == 3) rd_req = 1'b0;
        end

        // Reset right after a read grant drops the pending rd_vld
        rd_req = 1'b1; rd_ar = 5'd1; rd_br = 5'd2;
        step();
        rd_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rand_stim();
            step();
        end
        rst_n = 1'b1; wa_req = 1'b0; wm_req = 1'b0; rd_req = 1'b0;
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
